// File: rtl/handshake_pkg.sv
// Shared helpers for the handshake round-robin arbiter: index-width function
// and output-register reset values.
package handshake_pkg;

    localparam logic RST_M_VALID = 1'b0;
    localparam logic RST_M_LAST  = 1'b0;
    localparam int   RST_M_ID    = 0;

    // Bounded loop keeps this usable as a constant function during elaboration.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/handshake_rr_pick.sv
// Combinational rotating-priority picker: returns the first requesting port
// found when scanning cyclically upward from prio.
module handshake_rr_pick
    import handshake_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int ID_WIDTH  = 1
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [ID_WIDTH-1:0]  prio,
    output logic [ID_WIDTH-1:0]  grant_id,
    output logic                 grant_any
);

    int idx;

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        grant_id  = '0;
        grant_any = 1'b0;
        idx       = 0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            idx = int'(prio) + i;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end
            if (idx < NUM_PORTS) begin
                if (req[idx]) begin
                    grant_id  = ID_WIDTH'(idx);
                    grant_any = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/handshake_rr_arbiter.sv
// Round-robin merge of NUM_PORTS valid/ready streams into one registered output.
// Define HANDSHAKE_RR_ARBITER_PACKET_LOCK_EN to hold the grant until s_last.
module handshake_rr_arbiter
    import handshake_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int DATA_WIDTH = 1,
    localparam int ID_WIDTH  = clog2(NUM_PORTS)
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic [NUM_PORTS-1:0]            s_valid,
    output logic [NUM_PORTS-1:0]            s_ready,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_data,
    input  logic [NUM_PORTS-1:0]            s_last,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [DATA_WIDTH-1:0]           m_data,
    output logic                            m_last,
    output logic [ID_WIDTH-1:0]             m_id
);

    logic [ID_WIDTH-1:0]   rg_prio;
    logic                  rg_resetting;
    logic [ID_WIDTH-1:0]   pick_id;
    logic                  pick_any;
    logic [ID_WIDTH-1:0]   w_grant;
    logic                  w_grant_any;
    logic                  w_take;
    logic                  w_accept;
    logic                  w_beat_last;
    logic [ID_WIDTH-1:0]   w_prio_next;
    logic [DATA_WIDTH-1:0] port_data [NUM_PORTS];

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
            assign port_data[gi] = s_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    handshake_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .ID_WIDTH  (ID_WIDTH)
    ) u_pick (
        .req       (s_valid),
        .prio      (rg_prio),
        .grant_id  (pick_id),
        .grant_any (pick_any)
    );

    assign w_take = !m_valid || m_ready;

`ifdef HANDSHAKE_RR_ARBITER_PACKET_LOCK_EN
    logic                rg_locked;
    logic [ID_WIDTH-1:0] rg_owner;

    // A locked owner keeps the grant even while idle so no other port slips in mid-packet.
    assign w_grant     = rg_locked ? rg_owner : pick_id;
    assign w_grant_any = rg_locked ? 1'b1 : pick_any;
    assign w_beat_last = s_last[w_grant];
`else
    logic unused_last;

    assign unused_last = ^s_last;
    assign w_grant     = pick_id;
    assign w_grant_any = pick_any;
    assign w_beat_last = 1'b1;
`endif

    always_comb begin
        s_ready = '0;
        if (w_grant_any && w_take && !rg_resetting) begin
            s_ready[w_grant] = 1'b1;
        end
    end

    assign w_accept = s_valid[w_grant] && s_ready[w_grant];

    assign w_prio_next = (w_grant == ID_WIDTH'(NUM_PORTS - 1)) ? '0 : w_grant + 1'b1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_valid      <= RST_M_VALID;
            m_data       <= '0;
            m_last       <= RST_M_LAST;
            m_id         <= ID_WIDTH'(RST_M_ID);
            rg_prio      <= '0;
            rg_resetting <= 1'b1;
        end else begin
            rg_resetting <= 1'b0;
            if (w_accept) begin
                m_valid <= 1'b1;
                m_data  <= port_data[w_grant];
                m_last  <= w_beat_last;
                m_id    <= w_grant;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
            if (w_accept && w_beat_last) begin
                rg_prio <= w_prio_next;
            end
        end
    end

`ifdef HANDSHAKE_RR_ARBITER_PACKET_LOCK_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rg_locked <= 1'b0;
            rg_owner  <= '0;
        end else if (w_accept) begin
            rg_locked <= !w_beat_last;
            if (!w_beat_last) begin
                rg_owner <= w_grant;
            end
        end
    end
`endif

endmodule
